// File: rtl/display_codes_pkg.sv
// Shared display constants and FSM state type for the seven-segment path.
package display_codes_pkg;

  // Decoder codes. The decoder stage uses these same values.
  localparam logic [31:0] CODE_BLANK = 32'd98;
  localparam logic [31:0] CODE_MINUS = 32'd99;
  localparam logic [31:0] CODE_DP    = 32'd97;
  localparam logic [31:0] HEX_MIN    = 32'd0;
  localparam logic [31:0] HEX_MAX    = 32'd15;

  // Number of displays driven by the formatter and BCD digits produced.
  localparam int NUM_DIGITS = 6;
  localparam int NUM_BCD    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_FMT  = 2'd2
  } fmt_state_t;

endpackage

// File: rtl/bcd_adjust.sv
// Double-dabble nibble correction: add 3 to a BCD digit that is 5 or more.
module bcd_adjust (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/display_formatter.sv
// Converts a signed 16-bit value into six decoder codes, either as blanked
// signed decimal (serial double-dabble) or as a raw 4-digit hex pattern.
module display_formatter
  import display_codes_pkg::*;
#(
  parameter logic [31:0] CODE_BLANK = display_codes_pkg::CODE_BLANK,
  parameter logic [31:0] CODE_MINUS = display_codes_pkg::CODE_MINUS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] value,
  input  logic        hex_mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] dig0,
  output logic [31:0] dig1,
  output logic [31:0] dig2,
  output logic [31:0] dig3,
  output logic [31:0] dig4,
  output logic [31:0] dig5
);

  fmt_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] mag_q, mag_d;
  logic [19:0] bcd_q, bcd_d;
  logic [15:0] raw_q, raw_d;
  logic        neg_q, neg_d;
  logic        hex_q, hex_d;
  logic        done_q, done_d;
  logic [31:0] dig_q [NUM_DIGITS];
  logic [31:0] dig_d [NUM_DIGITS];

  logic [19:0] bcd_adj;
  logic [31:0] fmt_dig [NUM_DIGITS];
  logic [2:0]  msd;

  // Five parallel nibble corrections feeding the shift of each iteration.
  for (genvar g = 0; g < NUM_BCD; g++) begin : g_adj
    bcd_adjust u_adj (
      .nib_i (bcd_q[4*g +: 4]),
      .nib_o (bcd_adj[4*g +: 4])
    );
  end

  // Build the display codes from the finished BCD result or the raw value.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    msd = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) fmt_dig[i] = CODE_BLANK;
    if (hex_q) begin
      for (int i = 0; i < 4; i++) fmt_dig[i] = {28'd0, raw_q[4*i +: 4]};
    end else begin
      for (int i = 1; i < NUM_BCD; i++) begin
        if (bcd_q[4*i +: 4] != 4'd0) msd = 3'(i);
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (3'(i) <= msd) begin
          fmt_dig[i] = {28'd0, bcd_q[4*i +: 4]};
        end else if (neg_q && (3'(i) == msd + 3'd1)) begin
          fmt_dig[i] = CODE_MINUS;
        end
      end
    end
  end

  // Next-state and datapath control for IDLE -> CONV -> FMT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    raw_d   = raw_q;
    neg_d   = neg_q;
    hex_d   = hex_q;
    done_d  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) dig_d[i] = dig_q[i];

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          hex_d   = hex_mode;
          neg_d   = value[15];
          // Negating -32768 wraps back to 0x8000, which is the correct magnitude.
          mag_d   = value[15] ? 16'(-value) : value;
          raw_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = ST_FMT;
      end
      ST_FMT: begin
        for (int i = 0; i < NUM_DIGITS; i++) dig_d[i] = fmt_dig[i];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      bcd_q   <= '0;
      raw_q   <= '0;
      neg_q   <= 1'b0;
      hex_q   <= 1'b0;
      done_q  <= 1'b0;
      // NOTE: the display array is a handful of flops, not a RAM, so it is reset
      // to blank like any other visible output.
      for (int i = 0; i < NUM_DIGITS; i++) dig_q[i] <= CODE_BLANK;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      raw_q   <= raw_d;
      neg_q   <= neg_d;
      hex_q   <= hex_d;
      done_q  <= done_d;
      for (int i = 0; i < NUM_DIGITS; i++) dig_q[i] <= dig_d[i];
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign dig0 = dig_q[0];
  assign dig1 = dig_q[1];
  assign dig2 = dig_q[2];
  assign dig3 = dig_q[3];
  assign dig4 = dig_q[4];
  assign dig5 = dig_q[5];

endmodule

// File: tb/tb_display_formatter.sv
// Directed bench for display_formatter: latency, decimal/hex formatting,
// reset abort, ignored starts and back-to-back operation.
module tb_display_formatter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] value;
  logic        hex_mode;
  logic        busy;
  logic        done;
  logic [31:0] dig0, dig1, dig2, dig3, dig4, dig5;

  int n_cmp = 0;
  int n_err = 0;

  display_formatter dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .value    (value),
    .hex_mode (hex_mode),
    .busy     (busy),
    .done     (done),
    .dig0     (dig0),
    .dig1     (dig1),
    .dig2     (dig2),
    .dig3     (dig3),
    .dig4     (dig4),
    .dig5     (dig5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_digits(input string tag, input int e5, input int e4, input int e3,
                              input int e2, input int e1, input int e0);
    check({tag, " dig5"}, dig5, 32'(e5));
    check({tag, " dig4"}, dig4, 32'(e4));
    check({tag, " dig3"}, dig3, 32'(e3));
    check({tag, " dig2"}, dig2, 32'(e2));
    check({tag, " dig1"}, dig1, 32'(e1));
    check({tag, " dig0"}, dig0, 32'(e0));
  endtask

  // One conversion: launch, run a fixed 40-cycle window, check latency,
  // pulse count, busy/done exclusivity and the resulting digits.
  task automatic conv(input string tag, input logic [15:0] v, input logic hx, input bit inject,
                      input int e5, input int e4, input int e3,
                      input int e2, input int e1, input int e0);
    int first_done = -1;
    int n_done     = 0;
    int overlap    = 0;
    @(negedge clk);
    value    = v;
    hex_mode = hx;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy after start"}, 32'(busy), 32'd1);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = i;
      end
      if (busy && done) overlap++;
      if (inject && (i == 3 || i == 9)) begin
        start    = 1'b1;
        value    = 16'd999;
        hex_mode = ~hx;
      end else begin
        start = 1'b0;
      end
      if (first_done == i) check_digits(tag, e5, e4, e3, e2, e1, e0);
      if (first_done >= 0 && i == first_done + 1) check({tag, " done clears"}, 32'(done), 32'd0);
    end
    check({tag, " latency"}, 32'(first_done), 32'd17);
    check({tag, " done count"}, 32'(n_done), 32'd1);
    check({tag, " busy&done overlap"}, 32'(overlap), 32'd0);
    check_digits({tag, " hold"}, e5, e4, e3, e2, e1, e0);
  endtask

  initial begin
    int n_done;
    int t_done [3];

    rst      = 1'b1;
    start    = 1'b0;
    value    = '0;
    hex_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check_digits("reset", 98, 98, 98, 98, 98, 98);
    rst = 1'b0;

    conv("dec 12345", 16'd12345, 1'b0, 1'b0, 98, 1, 2, 3, 4, 5);

    // Reset aborts a conversion partway through CONV.
    @(negedge clk);
    value = 16'd321;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort busy before rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check_digits("abort", 98, 98, 98, 98, 98, 98);
    @(negedge clk);
    rst    = 1'b0;
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("abort no activity", 32'(n_done), 32'd0);

    conv("dec -5",     16'hFFFB,  1'b0, 1'b0, 98, 98, 98, 98, 99, 5);
    conv("dec 0",      16'd0,     1'b0, 1'b0, 98, 98, 98, 98, 98, 0);
    conv("dec -32768", 16'h8000,  1'b0, 1'b0, 99, 3, 2, 7, 6, 8);
    conv("dec 32767",  16'h7FFF,  1'b0, 1'b0, 98, 3, 2, 7, 6, 7);
    conv("dec -1000",  16'hFC18,  1'b0, 1'b0, 98, 99, 1, 0, 0, 0);
    conv("hex 0A3F",   16'h0A3F,  1'b1, 1'b0, 98, 98, 0, 10, 3, 15);
    conv("hex 8001",   16'h8001,  1'b1, 1'b0, 98, 98, 8, 0, 0, 1);
    conv("ignored start", 16'd7,  1'b0, 1'b1, 98, 98, 98, 98, 98, 7);

    // start held high: a new conversion every 18 clocks.
    @(negedge clk);
    value    = 16'd42;
    hex_mode = 1'b0;
    start    = 1'b1;
    n_done   = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (n_done < 3) t_done[n_done] = i;
        n_done++;
      end
    end
    start = 1'b0;
    check("held done count", 32'(n_done), 32'd3);
    check("held first latency", 32'(t_done[0]), 32'd18);
    check("held period 1", 32'(t_done[1] - t_done[0]), 32'd18);
    check("held period 2", 32'(t_done[2] - t_done[1]), 32'd18);
    check_digits("held", 98, 98, 98, 98, 4, 2);
    repeat (20) @(negedge clk);
    check("idle after held", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/display_formatter.md
# display_formatter

Sequential formatter that converts a 16-bit two's-complement value into six digit codes for the board's six seven-segment decoders, one decoder per HEX display. It sits directly upstream of the decoder stage: each `dig*` output drives the 32-bit `data` input of one decoder instance. Decimal mode uses a serial shift-add-3 (double-dabble) conversion with leading-zero blanking and a minus sign; hex mode shows the raw 16-bit pattern.

## Interface
- `CODE_BLANK`, default 98: decoder code for an all-off digit.
- `CODE_MINUS`, default 99: decoder code for the minus segment.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a conversion; sampled only in IDLE.
- `value`  in  16  signed two's-complement operand; sampled with `start`.
- `hex_mode`  in  1  1 = raw hex display, 0 = signed decimal; sampled with `start`.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse when new `dig*` values are registered.
- `dig0` … `dig5`  out  32 each  decoder codes; `dig0` is the rightmost display, `dig5` the leftmost. Values are 0–15 (digit), `CODE_BLANK` or `CODE_MINUS`.

## Operation
- States: IDLE, CONV, FMT.
- IDLE:
  - `start`=1 latches `hex_mode`, the sign bit, and a 16-bit unsigned magnitude: `-value` if negative, else `value`. -32768 gives magnitude 0x8000.
  - Also latches the raw `value` for hex mode, clears the 20-bit BCD register and the iteration counter, then moves to CONV.
- CONV:
  - Runs 16 iterations, one per clock.
  - Each iteration adds 3 to every BCD nibble ≥5, then shifts {bcd, mag} left by 1.
  - After the 16th iteration, moves to FMT.
  - Hex mode also runs all 16 iterations, so latency is identical in both modes; its BCD result is discarded.
- FMT:
  - Registers all six `dig*`, pulses `done`, returns to IDLE.
- Decimal formatting (BCD digits d4..d0):
  - `dig0`=d0 always.
  - Leading zeros from d4 downward are replaced with `CODE_BLANK`, stopping at the first nonzero digit or at d0.
  - If negative, `CODE_MINUS` goes in the display immediately left of the most-significant shown digit. Otherwise that display is blank.
  - All remaining displays are blank.
  - Zero shows `dig0`=0 with all others blank.
- Hex formatting:
  - `dig3..dig0` = `value[15:12]..value[3:0]`, no leading-zero blanking.
  - `dig5`, `dig4` = `CODE_BLANK`. Sign is not shown.
- `dig*` hold their last value until the next FMT; they never show intermediate results.
- `start` while in CONV or FMT is ignored (no queueing).
- Decimal-point codes (16–31, 97) are never generated.

## Timing
- Reset values: `busy`=0, `done`=0, every `dig*`=`CODE_BLANK`, state IDLE, counter 0.
- `rst` asserted mid-conversion aborts immediately. Outputs go to reset values; no `done` is issued.
- Edge k samples `start`=1 in IDLE:
  - `busy`=1 from edge k.
  - Edges k+1..k+16 perform the iterations.
  - Edge k+17 registers `dig*`, sets `done`=1 and `busy`=0.
  - Edge k+18 clears `done`.
- Latency from `start` edge to valid `dig*`: 17 clocks. Minimum repeat period: 18 clocks.
- `start` held high continuously launches a new conversion on the edge after `done` is asserted (state is IDLE that cycle).
- `busy` and `done` are never high in the same cycle.

## Structure
- Shared package/include `display_codes`: `CODE_BLANK`=98, `CODE_MINUS`=99, `CODE_DP`=97, and the hex digit range 0–15. The decoder stage uses the same constants.
- One natural sub-module, `bcd_adjust`: combinational 4-bit "add 3 if ≥5", instantiated five times inside the CONV datapath.
- FSM, counter, magnitude/BCD shift register and formatting logic stay in `display_formatter`.

## Test plan
- Reset asserted mid-CONV (cycle 8) → `busy`=0, no `done`, all `dig*`=98; a following `start` completes normally.
- Decimal `value`=12345 → after 17 clocks `done` pulses; `dig5..dig0` = 98,1,2,3,4,5.
- Decimal `value`=-5 → `dig5..dig0` = 98,98,98,98,99,5. Decimal `value`=0 → 98,98,98,98,98,0.
- Decimal `value`=-32768 → 99,3,2,7,6,8. Decimal `value`=32767 → 98,3,2,7,6,7.
- Hex `value`=16'h0A3F → 98,98,0,10,3,15, same 17-clock latency.
- `start` pulsed at cycles 3 and 10 of a conversion → ignored; exactly one `done`; `start` held high → `done` every 18 clocks.
